hazard_stall_controller: RTL

- Parametrised successor to the pipeline's load-use hazard detector.
- Sits beside the ID/EX stage and drives stall and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles load-use hazards with a configurable bubble count, stalls for a multi-cycle mul/div unit, and a global freeze on memory busywait.
- Counts stall cycles for performance monitoring.

---
 rtl/hazard_stall_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Load-use / mul-div hazard stall controller beside the ID/EX stage.
// Drives PC/IF-ID stall, ID/EX bubble, ID/EX hold and EX/MEM bubble, a global
// freeze on memory busywait, and a saturating count of stalled cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no multi-cycle stall in progress; hazards accepted here
// LU_STALL | inserting the remaining load-use bubbles into ID/EX
// MD_BUSY  | mul/div occupying EX; hold ID/EX, bubble EX/MEM
module hazard_stall_controller #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MULDIV_LATENCY   = 4,
  parameter int STAT_WIDTH       = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [REG_ADDR_WIDTH-1:0] ID_ADDR1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_ADDR2,
  input  logic                      ID_OPERAND1_SELECT,
  input  logic                      ID_OPERAND2_SELECT,
  input  logic [REG_ADDR_WIDTH-1:0] EX_REG_WRITE_ADDR,
  input  logic                      EX_DATA_MEM_READ,
  input  logic                      EX_MULDIV_START,
  input  logic                      INST_MEM_BUSYWAIT,
  input  logic                      DATA_MEM_BUSYWAIT,
  output logic                      PC_STALL,
  output logic                      ID_EX_BUBBLE,
  output logic                      EX_HOLD,
  output logic                      EX_MEM_BUBBLE,
  output logic                      FREEZE,
  output logic                      LU_HAZ_SIG,
  output logic [STAT_WIDTH-1:0]     STALL_CYCLES
);

  localparam int CNT_W = 5;
  // Counter preload: cycles still to spend in the stall state after the first one.
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MULDIV_LATENCY - 2);
  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LOAD_USE_BUBBLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STAT_WIDTH-1:0] stat_q;
  logic                  lu_haz;
  logic                  freeze;

  // Load-use detect: load in EX writing a non-x0 register that ID reads from the register file.
  always_comb begin
    lu_haz = 1'b0;
    if (!RESET && EX_DATA_MEM_READ && (EX_REG_WRITE_ADDR != '0)) begin
      lu_haz = (!ID_OPERAND1_SELECT && (ID_ADDR1 == EX_REG_WRITE_ADDR)) ||
               (!ID_OPERAND2_SELECT && (ID_ADDR2 == EX_REG_WRITE_ADDR));
    end
  end

  assign freeze       = !RESET && (INST_MEM_BUSYWAIT || DATA_MEM_BUSYWAIT);
  assign FREEZE       = freeze;
  assign LU_HAZ_SIG   = lu_haz;
  assign STALL_CYCLES = stat_q;

  // Next-state and stall controls; freeze holds everything and only stalls the front end.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PC_STALL      = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_HOLD       = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    if (RESET) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (freeze) begin
      PC_STALL = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (EX_MULDIV_START && (MULDIV_LATENCY > 1)) begin
            PC_STALL      = 1'b1;
            EX_HOLD       = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            if (MULDIV_LATENCY > 2) begin
              state_d = MD_BUSY;
              cnt_d   = MD_INIT;
            end
          end else if (lu_haz) begin
            PC_STALL     = 1'b1;
            ID_EX_BUBBLE = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_INIT;
            end
          end
        end
        LU_STALL: begin
          PC_STALL     = 1'b1;
          ID_EX_BUBBLE = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        MD_BUSY: begin
          PC_STALL      = 1'b1;
          EX_HOLD       = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
          cnt_d         = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and stall-counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating count of cycles with the front end stalled, freeze included.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_q <= '0;
    end else if (PC_STALL && !(&stat_q)) begin
      stat_q <= stat_q + STAT_WIDTH'(1);
    end
  end

endmodule
